// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Bytes assembled into one memory word (little-endian lanes)
    localparam int c_bytes_per_word = 4;
    // Length header is a single 32-bit little-endian word count
    localparam int c_header_bytes   = 4;
    // Width of the byte-lane counter inside the packer
    localparam int c_lane_width     = $clog2(c_bytes_per_word);

    // Loader control states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_byte_packer
//  Description : Little-endian byte-to-word assembler. Lane 0 lands in bits
//                [7:0]. When the last lane is accepted the full word is
//                presented combinationally with a one-cycle o_word_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_clr,
    input  logic [7:0]                      i_byte,
    input  logic                            i_byte_valid,
    output logic [8*c_bytes_per_word-1:0]   o_word,
    output logic                            o_word_valid
);

    localparam logic [c_lane_width-1:0] c_last_lane = c_lane_width'(c_bytes_per_word - 1);

    logic [c_lane_width-1:0]              r_lane;
    logic [8*(c_bytes_per_word-1)-1:0]    r_bytes;

    // Store lower lanes and advance the lane counter on every accepted byte
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_lane  <= '0;
            r_bytes <= '0;
        end else if (i_byte_valid) begin
            for (int i = 0; i < c_bytes_per_word - 1; i++) begin
                if (r_lane == c_lane_width'(i)) begin
                    r_bytes[i*8 +: 8] <= i_byte;
                end
            end
            r_lane <= r_lane + 1'b1;
        end
    end

    // The top lane bypasses storage so the word is ready in the accepting cycle
    always_comb begin
        o_word       = {i_byte, r_bytes};
        o_word_valid = i_byte_valid && (r_lane == c_last_lane);
    end

endmodule : imem_loader_byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction-memory writer. Consumes a byte stream made of a
//                32-bit little-endian word count, the image words, and an
//                8-bit additive checksum; writes each word to memory and holds
//                the CPU in reset until a load completes successfully.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    // Largest legal word count: the full memory capacity
    localparam logic [32:0]       c_max_words = 33'd1 << ADDR_WIDTH;
    localparam logic [29:0]       c_base_word = BASE_ADDR[31:2];
    localparam logic [ADDR_WIDTH:0] c_one     = (ADDR_WIDTH+1)'(1);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_start;
    logic                   w_accepting;
    logic                   w_xfer;
    logic                   w_pack_valid;
    logic [31:0]            w_word;
    logic                   w_word_valid;
    logic                   w_hdr_word;
    logic                   w_data_word;
    logic                   w_oversize;
    logic                   w_zero;

    logic [ADDR_WIDTH:0]    r_remaining;
    logic [7:0]             r_csum;
    logic [29:0]            r_word_addr;
    logic                   r_mem_we;
    logic [31:0]            r_wdata;

    // Byte acceptance is purely a function of state, which keeps the
    // handshake free of combinational feedback
    assign w_accepting  = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
    assign rx_ready     = w_accepting;
    assign busy         = w_accepting;
    assign w_xfer       = rx_valid && w_accepting;
    assign w_pack_valid = w_xfer && ((r_state == LEN) || (r_state == DATA));
    assign w_hdr_word   = w_word_valid && (r_state == LEN);
    assign w_data_word  = w_word_valid && (r_state == DATA);
    assign w_oversize   = {1'b0, w_word} > c_max_words;
    assign w_zero       = (w_word == 32'd0);

    assign mem_we    = r_mem_we;
    assign mem_addr  = {r_word_addr, 2'b00};
    assign mem_wdata = r_wdata;

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start),
        .i_byte       (rx_data),
        .i_byte_valid (w_pack_valid),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start = 1'b1;
                    w_next  = LEN;
                end
            end
            LEN: begin
                if (w_hdr_word) begin
                    if (w_oversize) begin
                        w_next = ERR;
                    end else if (w_zero) begin
                        w_next = CSUM;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_data_word && (r_remaining == c_one)) begin
                    w_next = CSUM;
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    w_next = (rx_data == r_csum) ? DONE : ERR;
                end
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    w_start = 1'b1;
                    w_next  = LEN;
                end
            end
            ERR: begin
                error = 1'b1;
                if (start) begin
                    w_start = 1'b1;
                    w_next  = LEN;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: word count, checksum, write strobe/data and address.
    // The write lands one cycle after the top lane; the address advances at
    // the end of that write cycle so mem_addr is stable while mem_we is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_csum      <= '0;
            r_word_addr <= c_base_word;
            r_mem_we    <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_mem_we <= w_data_word;
            if (w_data_word) begin
                r_wdata <= w_word;
            end
            if (r_mem_we) begin
                r_word_addr <= r_word_addr + 30'd1;
            end
            if (w_hdr_word) begin
                r_remaining <= w_word[ADDR_WIDTH:0];
            end else if (w_data_word) begin
                r_remaining <= r_remaining - c_one;
            end
            if (w_xfer && (r_state == DATA)) begin
                r_csum <= r_csum + rx_data;
            end
            if (w_start) begin
                r_csum      <= '0;
                r_remaining <= '0;
                r_word_addr <= c_base_word;
            end
        end
    end

endmodule : imem_loader
`default_nettype wire
